// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 registered demultiplexer.
package demux_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned N_OUT = 8;

    localparam logic [SEL_W-1:0] SEL_OUT1 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_OUT2 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_OUT3 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_OUT4 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_OUT5 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_OUT6 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_OUT7 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_OUT8 = 3'd7;

    typedef logic [N_OUT-1:0] onehot_t;

endpackage

// File: rtl/demux_dec3to8.sv
// Combinational 3-to-8 one-hot decoder; an unknown select yields all zeros.
module demux_dec3to8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    output onehot_t          onehot_c
);

    // Case equality in simulation sends X/Z select to the all-zero default.
    always_comb begin
        onehot_c = '0;
        case (sel_i)
            SEL_OUT1: onehot_c[0] = 1'b1;
            SEL_OUT2: onehot_c[1] = 1'b1;
            SEL_OUT3: onehot_c[2] = 1'b1;
            SEL_OUT4: onehot_c[3] = 1'b1;
            SEL_OUT5: onehot_c[4] = 1'b1;
            SEL_OUT6: onehot_c[5] = 1'b1;
            SEL_OUT7: onehot_c[6] = 1'b1;
            SEL_OUT8: onehot_c[7] = 1'b1;
            default:  onehot_c = '0;
        endcase
    end

endmodule

// File: rtl/demux_1to8.sv
// 1-to-8 registered demultiplexer: routes datain to the selected output one
// cycle later and clears the other seven outputs on the same edge.
module demux_1to8
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] select,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic [WIDTH-1:0] out_5,
    output logic [WIDTH-1:0] out_6,
    output logic [WIDTH-1:0] out_7,
    output logic [WIDTH-1:0] out_8
);

    onehot_t          onehot;
    logic [WIDTH-1:0] out_d [N_OUT];
    logic [WIDTH-1:0] out_q [N_OUT];

    demux_dec3to8 u_dec (
        .sel_i    (select),
        .onehot_c (onehot)
    );

    // Each one-hot bit gates datain into its own output's next value.
    always_comb begin
        for (int i = 0; i < int'(N_OUT); i++) begin
            out_d[i] = onehot[i] ? datain : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_OUT); i++) begin
                out_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_OUT); i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign out_1 = out_q[0];
    assign out_2 = out_q[1];
    assign out_3 = out_q[2];
    assign out_4 = out_q[3];
    assign out_5 = out_q[4];
    assign out_6 = out_q[5];
    assign out_7 = out_q[6];
    assign out_8 = out_q[7];

endmodule

// File: tb/tb_demux_1to8.sv
// Self-checking bench for demux_1to8: vector table plus scoreboard queue.
module tb_demux_1to8;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   select;
    logic [W-1:0] datain;
    logic [W-1:0] out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8;

    typedef logic [7:0][W-1:0] outs_t;

    typedef struct {
        logic         rst;
        logic [2:0]   sel;
        logic [W-1:0] data;
        int           exp_idx;   // 8 means every output expected zero
        logic [W-1:0] exp_val;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb[$];
    int    checks = 0;
    int    errors = 0;

    demux_1to8 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .datain (datain),
        .out_1  (out_1),
        .out_2  (out_2),
        .out_3  (out_3),
        .out_4  (out_4),
        .out_5  (out_5),
        .out_6  (out_6),
        .out_7  (out_7),
        .out_8  (out_8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic outs_t expect_of(int idx, logic [W-1:0] v);
        outs_t r = '0;
        if (idx < 8) r[idx] = v;
        return r;
    endfunction

    function automatic outs_t dut_outs();
        return {out_8, out_7, out_6, out_5, out_4, out_3, out_2, out_1};
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(string tag);
        outs_t act = dut_outs();
        outs_t exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h expected entry", tag, act);
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s out_%0d", tag, i + 1), act[i], exp[i]);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        rst    = v.rst;
        select = v.sel;
        datain = v.data;
        sb.push_back(expect_of(v.exp_idx, v.exp_val));
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst    = 1'b1;
        select = 3'd5;
        datain = 4'hC;

        // Reset held two cycles with live inputs
        vecs.push_back('{1'b1, 3'd5, 4'hC, 8, 4'h0});
        vecs.push_back('{1'b1, 3'd5, 4'hC, 8, 4'h0});
        // Select sweep with datain = 12
        vecs.push_back('{1'b0, 3'd0, 4'hC, 0, 4'hC});
        vecs.push_back('{1'b0, 3'd1, 4'hC, 1, 4'hC});
        vecs.push_back('{1'b0, 3'd2, 4'hC, 2, 4'hC});
        vecs.push_back('{1'b0, 3'd3, 4'hC, 3, 4'hC});
        vecs.push_back('{1'b0, 3'd4, 4'hC, 4, 4'hC});
        vecs.push_back('{1'b0, 3'd5, 4'hC, 5, 4'hC});
        vecs.push_back('{1'b0, 3'd6, 4'hC, 6, 4'hC});
        vecs.push_back('{1'b0, 3'd7, 4'hC, 7, 4'hC});
        // Switch-away: out_3 clears on the edge out_7 loads
        vecs.push_back('{1'b0, 3'd2, 4'hF, 2, 4'hF});
        vecs.push_back('{1'b0, 3'd6, 4'hF, 6, 4'hF});
        // Mid-stream reset then resume
        vecs.push_back('{1'b0, 3'd7, 4'h9, 7, 4'h9});
        vecs.push_back('{1'b0, 3'd7, 4'h9, 7, 4'h9});
        vecs.push_back('{1'b1, 3'd7, 4'h9, 8, 4'h0});
        vecs.push_back('{1'b0, 3'd7, 4'h9, 7, 4'h9});
        // Data sweep on out_1, including datain = 0
        for (int d = 0; d < 16; d++) begin
            vecs.push_back('{1'b0, 3'd0, W'(d), 0, W'(d)});
        end

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Latency: new select/data right after edge k must not show before edge k+1
        apply('{1'b0, 3'd0, 4'h5, 0, 4'h5}, "lat_pre");
        select = 3'd3;
        datain = 4'hA;
        sb.push_back(expect_of(3, 4'hA));
        #3;
        chk("lat_before out_4", out_4, 4'h0);
        chk("lat_before out_1", out_1, 4'h5);
        @(posedge clk);
        #1;
        compare_all("lat_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
